var_delay_pipe: RTL and testbench

Parametrised, multi-channel successor to the fixed delay register, used to align datapath operands in the Quadratic Approximation Unit. It delays CHANNELS words of WIDTH bits plus a shared valid flag by a delay set at runtime (0..MAX_DELAY). It supports pipeline stall, flush and occupancy reporting. It sits between the table lookup and the multiply/accumulate stages, where stage latency differs between approximation modes.

---
 rtl/var_delay_pipe.sv | 114 +++++++++++
 tb/tb_var_delay_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_delay_pipe.sv
// Runtime-variable delay line for CHANNELS words plus a shared valid flag.
// Ports: clk/rst (sync, active-high), en_i, flush_i, dly_i, valid_i, x_i -> valid_o, y_o, dly_o, cnt_o.
module var_delay_pipe #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 1,
  parameter int MAX_DELAY  = 8,
  parameter bit RESET_DATA = 1'b0,
  localparam int DW = $clog2(MAX_DELAY + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic [DW-1:0]             dly_i,
  input  logic                      valid_i,
  input  logic [CHANNELS*WIDTH-1:0] x_i,
  output logic                      valid_o,
  output logic [CHANNELS*WIDTH-1:0] y_o,
  output logic [DW-1:0]             dly_o,
  output logic [DW-1:0]             cnt_o
);

  localparam int XW = CHANNELS * WIDTH;

  logic [DW-1:0]        dly_r;
  logic [DW-1:0]        dly_c;
  logic [DW-1:0]        dly_n;
  logic [DW-1:0]        cnt_r;
  logic [DW-1:0]        cnt_n;
  logic [MAX_DELAY-1:0] vld_q;
  logic [MAX_DELAY-1:0] vld_n;
  logic [XW-1:0]        data_q [MAX_DELAY];
  logic [XW-1:0]        tap_d;
  logic                 tap_v;
  logic                 chg;
  logic                 flush_all;
  logic                 adv;

  assign dly_c = (dly_i > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : dly_i;

  // A delay change invalidates everything in flight.
  assign chg       = dly_c != dly_r;
  assign flush_all = flush_i | chg;
  assign adv       = en_i & ~flush_all;
  assign dly_n     = chg ? dly_c : dly_r;

  always_comb begin
    vld_n = vld_q;
    if (flush_all) begin
      vld_n = '0;
    end else if (en_i) begin
      vld_n[0] = valid_i;
      for (int k = 1; k < MAX_DELAY; k++) begin
        vld_n[k] = vld_q[k-1];
      end
    end
  end

  // Occupancy is counted on the next state so cnt_o is a plain register.
  always_comb begin
    cnt_n = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (DW'(k) < dly_n) begin
        cnt_n = cnt_n + DW'(vld_n[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_r <= dly_c;
      vld_q <= '0;
      cnt_r <= '0;
    end else begin
      dly_r <= dly_n;
      vld_q <= vld_n;
      cnt_r <= cnt_n;
    end
  end

  // Data shifts only on a clean advance; flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_DATA) begin
        for (int k = 0; k < MAX_DELAY; k++) begin
          data_q[k] <= '0;
        end
      end
    end else if (adv) begin
      data_q[0] <= x_i;
      for (int k = 1; k < MAX_DELAY; k++) begin
        data_q[k] <= data_q[k-1];
      end
    end
  end

  always_comb begin
    tap_d = '0;
    tap_v = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (DW'(k + 1) == dly_r) begin
        tap_d = data_q[k];
        tap_v = vld_q[k];
      end
    end
  end

  // Zero delay is a pure combinational bypass.
  assign valid_o = (dly_r == '0) ? (valid_i & en_i) : tap_v;
  assign y_o     = (dly_r == '0) ? x_i : tap_d;
  assign dly_o   = dly_r;
  assign cnt_o   = cnt_r;

endmodule

// File: tb/tb_var_delay_pipe.sv
// Bench for var_delay_pipe: age-based reference model plus directed vectors.
// A second instance (3 channels, data reset) covers mid-stream reset.
module tb_var_delay_pipe;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fl;
  logic [3:0]  dly;
  logic        vi;
  logic [15:0] x;
  logic        vo;
  logic [15:0] y;
  logic [3:0]  dlo;
  logic [3:0]  cnto;

  logic        rst2;
  logic        en2;
  logic        fl2;
  logic [3:0]  dly2;
  logic        vi2;
  logic [47:0] x2;
  logic        vo2;
  logic [47:0] y2;
  logic [3:0]  dlo2;
  logic [3:0]  cnt2;

  int nvec = 0;
  int nerr = 0;

  var_delay_pipe #(
    .WIDTH(16), .CHANNELS(1), .MAX_DELAY(8), .RESET_DATA(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .flush_i(fl), .dly_i(dly),
    .valid_i(vi), .x_i(x), .valid_o(vo), .y_o(y), .dly_o(dlo),
    .cnt_o(cnto)
  );

  var_delay_pipe #(
    .WIDTH(16), .CHANNELS(3), .MAX_DELAY(8), .RESET_DATA(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst2), .en_i(en2), .flush_i(fl2), .dly_i(dly2),
    .valid_i(vi2), .x_i(x2), .valid_o(vo2), .y_o(y2), .dly_o(dlo2),
    .cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampf(input logic [3:0] d);
    return (int'(d) > 8) ? 8 : int'(d);
  endfunction

  function automatic logic [47:0] w(input int k);
    logic [15:0] m;
    m = 16'(k * 'h0111);
    return {16'hFFFF ^ m, 16'h5A5A ^ m, 16'hA5A5 ^ m};
  endfunction

  // Model: each accepted word carries its age in enabled edges.
  // It is at the tap when age == delay; occupancy = words with age <= delay.
  typedef struct {
    int          age;
    logic [15:0] d;
  } ent_t;

  ent_t acc[$];
  int   mdly = 0;
  bit   mok = 1'b0;
  int   cc;

  always @(posedge clk) begin
    cc = clampf(dly);
    if (rst) begin
      mdly = cc;
      acc.delete();
      mok = 1'b1;
    end else if (cc != mdly) begin
      mdly = cc;
      acc.delete();
    end else if (fl) begin
      acc.delete();
    end else if (en) begin
      for (int i = acc.size() - 1; i >= 0; i--) begin
        acc[i].age = acc[i].age + 1;
        if (acc[i].age > 8) acc.delete(i);
      end
      if (vi) acc.push_back('{age: 1, d: x});
    end
  end

  logic        exp_v;
  logic [15:0] exp_y;
  int          exp_c;

  always @(negedge clk) begin
    if (mok) begin
      exp_v = 1'b0;
      exp_y = '0;
      exp_c = 0;
      if (mdly == 0) begin
        exp_v = vi & en;
        exp_y = x;
        chk("pass_y", y, exp_y);
      end else begin
        foreach (acc[i]) begin
          if (acc[i].age <= mdly) exp_c++;
          if (acc[i].age == mdly) begin
            exp_v = 1'b1;
            exp_y = acc[i].d;
          end
        end
        if (exp_v) chk("tap_y", y, exp_y);
      end
      chk("valid", vo, exp_v);
      chk("cnt", cnto, exp_c);
      chk("dly", dlo, mdly);
    end
  end

  int k;

  initial begin
    rst = 1'b1; en = 1'b1; fl = 1'b0; dly = 4'd3; vi = 1'b0; x = '0;
    rst2 = 1'b1; en2 = 1'b1; fl2 = 1'b0; dly2 = 4'd2; vi2 = 1'b0; x2 = '0;
    cyc();
    cyc();
    rst = 1'b0;
    #2;
    chk("rst_dly", dlo, 3);
    chk("rst_valid", vo, 0);
    chk("rst_cnt", cnto, 0);
    cyc();

    // stream at delay 3
    for (int i = 0; i < 16; i++) begin
      vi = 1'b1; x = 16'(i + 1);
      #2;
      if (i == 2) chk("t1_not_yet", vo, 0);
      if (i == 3) begin
        chk("t1_rise", vo, 1);
        chk("t1_first", y, 16'h0001);
      end
      if (i == 10) begin
        chk("t1_cnt_sat", cnto, 3);
        chk("t1_order", y, 16'h0008);
      end
      cyc();
    end
    vi = 1'b0;
    repeat (5) cyc();

    // stall mid-stream at delay 4
    dly = 4'd4;
    #2;
    cyc();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      en = !(i >= 8 && i <= 12);
      vi = 1'b1;
      x = en ? 16'(16'h0100 + k) : 16'hDEAD;
      #2;
      if (i == 10) begin
        chk("t2_hold_y", y, 16'h0104);
        chk("t2_hold_v", vo, 1);
        chk("t2_hold_cnt", cnto, 4);
      end
      if (i == 13) chk("t2_last_hold", y, 16'h0104);
      if (i == 14) chk("t2_resume", y, 16'h0105);
      cyc();
      if (en) k++;
    end
    en = 1'b1; vi = 1'b0;
    repeat (6) cyc();

    // runtime delay change 2 -> 5
    dly = 4'd2;
    #2;
    cyc();
    for (int i = 0; i < 8; i++) begin
      vi = 1'b1; x = 16'(16'h0200 + i);
      #2;
      cyc();
    end
    dly = 4'd5; vi = 1'b1; x = 16'h02FF;
    #2;
    cyc();
    for (int j = 0; j < 10; j++) begin
      vi = 1'b1; x = 16'(16'h0300 + j);
      #2;
      if (j == 0) begin
        chk("t3_dly5", dlo, 5);
        chk("t3_cleared", vo, 0);
      end
      if (j == 4) chk("t3_still_low", vo, 0);
      if (j == 5) begin
        chk("t3_rise", vo, 1);
        chk("t3_first_new", y, 16'h0300);
      end
      cyc();
    end
    vi = 1'b0;
    repeat (6) cyc();

    // flush at max delay
    dly = 4'd8;
    #2;
    cyc();
    for (int i = 0; i < 10; i++) begin
      vi = 1'b1; x = 16'(16'h0400 + i);
      #2;
      cyc();
    end
    fl = 1'b1; vi = 1'b1; x = 16'h0BAD;
    #2;
    chk("t4_pre_cnt", cnto, 8);
    chk("t4_pre_y", y, 16'h0402);
    cyc();
    fl = 1'b0; vi = 1'b0;
    #2;
    chk("t4_cnt0", cnto, 0);
    chk("t4_v0", vo, 0);
    cyc();
    repeat (10) cyc();

    // zero delay passthrough
    dly = 4'd0;
    #2;
    cyc();
    en = 1'b1; vi = 1'b1; x = 16'h1234;
    #2;
    chk("t5_pass_v", vo, 1);
    chk("t5_pass_y", y, 16'h1234);
    chk("t5_pass_cnt", cnto, 0);
    cyc();
    en = 1'b0; vi = 1'b1; x = 16'h4321;
    #2;
    chk("t5_stall_v", vo, 0);
    chk("t5_stall_y", y, 16'h4321);
    cyc();
    en = 1'b1; vi = 1'b0; x = 16'h9999;
    #2;
    chk("t5_novalid", vo, 0);
    cyc();

    // clamp 15 -> 8
    dly = 4'd15;
    #2;
    cyc();
    for (int i = 0; i < 12; i++) begin
      vi = 1'b1; x = 16'(16'h5000 + i);
      #2;
      if (i == 0) chk("t6_clamp", dlo, 8);
      if (i == 7) chk("t6_not_yet", vo, 0);
      if (i == 8) begin
        chk("t6_rise", vo, 1);
        chk("t6_first", y, 16'h5000);
      end
      cyc();
    end
    vi = 1'b0;

    // three channels, mid-stream reset with data clear
    for (int c = 0; c < 11; c++) begin
      rst2 = (c == 4);
      vi2 = 1'b1;
      x2 = (c < 5) ? w(c) : w(10 + c - 5);
      #2;
      if (c == 2) begin
        chk("c3_first_v", vo2, 1);
        chk("c3_first_y", y2, w(0));
      end
      if (c == 3) begin
        chk("c3_second_y", y2, w(1));
        chk("c3_cnt", cnt2, 2);
      end
      if (c == 4) chk("c3_prerst_y", y2, w(2));
      if (c == 5) begin
        chk("c3_rst_v", vo2, 0);
        chk("c3_rst_cnt", cnt2, 0);
        chk("c3_rst_y", y2, 48'h0);
        chk("c3_rst_dly", dlo2, 2);
      end
      if (c == 6) begin
        chk("c3_empty_v", vo2, 0);
        chk("c3_empty_y", y2, 48'h0);
      end
      if (c == 7) begin
        chk("c3_after_v", vo2, 1);
        chk("c3_after_y", y2, w(10));
        chk("c3_after_cnt", cnt2, 2);
      end
      if (c == 8) chk("c3_next_y", y2, w(11));
      cyc();
    end
    vi2 = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
